// File: rtl/ula_div_pkg.sv
// ============================================================================
// ula_div_pkg : shared types and constants for the multi-cycle ULA divider
// Rev 1.0
// ============================================================================
`default_nettype none

package ula_div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_REM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ula_div_if.sv
// ============================================================================
// ula_div_if : start/busy/done handshake and operand/result bus of ula_div
// Rev 1.0
// ============================================================================
`default_nettype none

interface ula_div_if
  import ula_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             op_rem;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_zero;

  // Control unit side
  modport master (
    output start, op_rem, A, B,
    input  quotient, remainder, result, zero, busy, done, div_zero
  );

  // Divider side
  modport slave (
    input  start, op_rem, A, B,
    output quotient, remainder, result, zero, busy, done, div_zero
  );

endinterface

`default_nettype wire

// File: rtl/ula_div_step.sv
// ============================================================================
// ula_div_step : one restoring shift-subtract iteration (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module ula_div_step
  import ula_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic [WIDTH-1:0] r_in,
  input  wire logic [WIDTH-1:0] q_in,
  input  wire logic [WIDTH-1:0] b_in,
  output logic      [WIDTH-1:0] r_out,
  output logic      [WIDTH-1:0] q_out
);

  // One extra bit keeps the shifted-out MSB of R in the compare.
  logic [WIDTH:0] w_trial;
  logic           w_ge;

  always_comb begin
    w_trial = {r_in, q_in[WIDTH-1]};
    w_ge    = (w_trial >= {1'b0, b_in});
    r_out   = w_ge ? WIDTH'(w_trial - {1'b0, b_in}) : w_trial[WIDTH-1:0];
    q_out   = {q_in[WIDTH-2:0], w_ge};
  end

endmodule

`default_nettype wire

// File: rtl/ula_div.sv
// ============================================================================
// ula_div : multi-cycle unsigned divider, one quotient bit per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module ula_div
  import ula_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  wire logic clock,
  input  wire logic reset,
  ula_div_if.slave  bus
);

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]   r_q,         r_d;
  logic [WIDTH-1:0]   qw_q,        qw_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic [WIDTH-1:0]   quotient_q,  quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_zero_q,  div_zero_d;
  logic               op_rem_q,    op_rem_d;

  logic [WIDTH-1:0]   w_step_r;
  logic [WIDTH-1:0]   w_step_q;
  logic               w_last;

  ula_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_in  (r_q),
    .q_in  (qw_q),
    .b_in  (b_q),
    .r_out (w_step_r),
    .q_out (w_step_q)
  );

  assign w_last = (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = (bus.B != '0) ? S_CALC : S_DONE;
      end
      S_CALC: begin
        if (w_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    r_d         = r_q;
    qw_d        = qw_q;
    b_d         = b_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    op_rem_d    = op_rem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          b_d      = bus.B;
          op_rem_d = bus.op_rem;
          if (bus.B != '0) begin
            r_d   = '0;
            qw_d  = bus.A;
            cnt_d = '0;
          end else begin
            // Divide by zero: all-ones quotient, dividend passes to remainder.
            quotient_d  = '1;
            remainder_d = bus.A;
            div_zero_d  = 1'b1;
          end
        end
      end
      S_CALC: begin
        r_d   = w_step_r;
        qw_d  = w_step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (w_last) begin
          quotient_d  = w_step_q;
          remainder_d = w_step_r;
          div_zero_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      r_q         <= '0;
      qw_q        <= '0;
      b_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      op_rem_q    <= OP_DIV;
    end else begin
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      qw_q        <= qw_d;
      b_q         <= b_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      op_rem_q    <= op_rem_d;
    end
  end

  // Outputs
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.quotient  = quotient_q;
    bus.remainder = remainder_q;
    bus.div_zero  = div_zero_q;
    bus.result    = (op_rem_q == OP_REM) ? remainder_q : quotient_q;
    bus.zero      = (bus.result == '0);
  end

endmodule

`default_nettype wire
